// File: rtl/execute_pkg.sv
// Shared execute-stage types: opcodes, branch condition codes, flag bundle and
// the opcode-to-flag-write classification.
package execute_pkg;

  typedef enum logic [3:0] {
    OpAdd = 4'h0,
    OpSub = 4'h1,
    OpXor = 4'h2,
    OpSll = 4'h4,
    OpSra = 4'h5,
    OpRor = 4'h6
  } opcode_e;

  typedef enum logic [2:0] {
    CcNeq    = 3'd0,
    CcEq     = 3'd1,
    CcGt     = 3'd2,
    CcLt     = 3'd3,
    CcGte    = 3'd4,
    CcLte    = 3'd5,
    CcOvfl   = 3'd6,
    CcUncond = 3'd7
  } ccc_e;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  typedef enum logic [1:0] {
    FcNone  = 2'd0,
    FcZOnly = 2'd1,
    FcZvn   = 2'd2
  } flag_class_e;

  // Which flags an opcode is allowed to write when it commits.
  function automatic flag_class_e flag_class(input logic [3:0] opcode);
    flag_class_e fc;
    case (opcode)
      OpAdd, OpSub:               fc = FcZvn;
      OpXor, OpSll, OpSra, OpRor: fc = FcZOnly;
      default:                    fc = FcNone;
    endcase
    return fc;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation against a Z/V/N flag set.
module branch_cond
  import execute_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic       z,
  input  logic       v,
  input  logic       n,
  output logic       cond
);

  // Decode the condition code into a single taken/not-taken bit.
  always_comb begin
    cond = 1'b0;
    unique case (ccc_e'(ccc))
      CcNeq:    cond = ~z;
      CcEq:     cond = z;
      CcGt:     cond = ~z & ~n;
      CcLt:     cond = n;
      CcGte:    cond = z | (~z & ~n);
      CcLte:    cond = n | z;
      CcOvfl:   cond = v;
      CcUncond: cond = 1'b1;
      default:  cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_flag_unit.sv
// Execute-stage back end: EX/MEM result register, architectural Z/V/N flags
// and branch resolution against the committed flags.
module ex_flag_unit
  import execute_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic        stall,
  input  logic        flush,
  input  logic [3:0]  opcode,
  input  logic [15:0] alu_out,
  input  logic        alu_err,
  input  logic        is_branch,
  input  logic [2:0]  ccc,
  output logic        flag_Z,
  output logic        flag_V,
  output logic        flag_N,
  output logic        branch_taken,
  output logic [15:0] ex_result,
  output logic        ex_valid
);

  logic        commit;
  logic        cond;
  flags_t      flags_q, flags_d;
  logic [15:0] result_q, result_d;
  logic        valid_q, valid_d;

  assign commit = valid_in & ~stall & ~flush;

  // Flag next state: only a committing instruction may write, limited by its class.
  always_comb begin
    flags_d = flags_q;
    if (commit) begin
      unique case (flag_class(opcode))
        FcZvn: begin
          flags_d.z = (alu_out == 16'h0000);
          flags_d.v = alu_err;
          flags_d.n = alu_out[15];
        end
        FcZOnly: flags_d.z = (alu_out == 16'h0000);
        default: flags_d = flags_q;
      endcase
    end
  end

  // Architectural flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  // EX/MEM next state: flush beats stall, stall beats normal flow.
  always_comb begin
    result_d = result_q;
    valid_d  = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = valid_in;
      if (valid_in) begin
        result_d = alu_out;
      end
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 16'h0000;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // Branches see only committed flags; no same-cycle bypass.
  branch_cond u_branch_cond (
    .ccc  (ccc),
    .z    (flags_q.z),
    .v    (flags_q.v),
    .n    (flags_q.n),
    .cond (cond)
  );

  assign branch_taken = valid_in & is_branch & ~flush & cond;
  assign flag_Z       = flags_q.z;
  assign flag_V       = flags_q.v;
  assign flag_N       = flags_q.n;
  assign ex_result    = result_q;
  assign ex_valid     = valid_q;

endmodule

// File: doc/ex_flag_unit.md
# ex_flag_unit

Execute-stage back end, directly downstream of the saturating 16-bit add/sub adder. Captures the adder/ALU result into the EX/MEM boundary, maintains the architectural Z/V/N flag register, and resolves branch conditions for a branch currently in EX against the committed flags. Honours pipeline stall and flush.

## Interface
- No parameters; data width fixed at 16.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  EX holds a valid instruction.
- stall  in  1  hold all state this cycle.
- flush  in  1  squash the EX instruction.
- opcode  in  4  EX instruction opcode.
- alu_out  in  16  ALU result, already saturated by the adder.
- alu_err  in  1  adder overflow/saturation indication.
- is_branch  in  1  EX instruction is a conditional branch (B or BR).
- ccc  in  3  branch condition code.
- flag_Z, flag_V, flag_N  out  1 each  committed flags.
- branch_taken  out  1  combinational branch resolution.
- ex_result  out  16  registered result to MEM.
- ex_valid  out  1  registered valid to MEM.

## Operation
- Commit condition: `commit = valid_in & ~stall & ~flush`.
- Flag write classes (decoded from opcode):
  - ADD 0000, SUB 0001: update Z, V, N.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: update Z only; V, N hold.
  - All other opcodes: no flag update.
- Flag values on commit:
  - Z = (alu_out == 16'h0000).
  - N = alu_out[15].
  - V = alu_err.
  - Saturated results flag normally, e.g. 0x7FFF gives N=0, Z=0, V=1.
- branch_taken = `valid_in & is_branch & ~flush & cond(ccc)`. It is evaluated against the committed flags and is never affected by the opcode or alu_out of the same cycle.
- cond(ccc):
  - 000 NEQ: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | (!Z & !N)
  - 101 LTE: N | Z
  - 110 OVFL: V
  - 111 UNCOND: 1
- EX/MEM register:
  - On commit: ex_result ← alu_out, ex_valid ← 1.
  - On flush, regardless of stall: ex_valid ← 0; ex_result and flags unchanged.
  - On stall without flush: ex_result, ex_valid and flags all hold.
  - valid_in=0 without stall or flush: ex_valid ← 0.
- Precedence: flush > stall > normal.

## Timing
- Reset (async assert on rst_n low, synchronous-safe deassert): flag_Z=flag_V=flag_N=0, ex_result=16'h0000, ex_valid=0.
- During reset branch_taken follows its equation, so it is 0 unless valid_in & is_branch.
- Flag latency is 1 cycle: a flag-setting instruction committing at edge k is visible to a branch in EX during cycle k+1. No bypass from the same cycle.
- Result latency is 1 cycle: alu_out at edge k appears on ex_result after edge k.
- If reset asserts mid-stall, stalled state is discarded and all outputs return to reset values immediately.
- A branch with ccc=111 is taken even when flags are reset values.

## Structure
- Shared package execute_pkg:
  - Opcode enum for the 4-bit opcodes.
  - ccc enum.
  - Flag struct {Z, V, N}.
  - Pure function `flag_class(opcode)` returning {NONE, Z_ONLY, ZVN}.
- One sub-module, branch_cond: combinational {ccc, Z, V, N} → cond. Instantiated once.
- Top level holds the flag register and the EX/MEM register in separate always_ff blocks with async active-low reset.

## Test plan
- Reset with rst_n=0 mid-cycle, valid_in=1, is_branch=1, ccc=001 → flags all 0, ex_valid=0, branch_taken=0. Then ccc=000 → branch_taken=1.
- ADD commit with alu_out=0x7FFF, alu_err=1 → next cycle Z=0, N=0, V=1, ex_result=0x7FFF, ex_valid=1. Branch ccc=110 in that cycle → taken=1.
- SUB commit with alu_out=0x0000, alu_err=0 → Z=1, N=0, V=0. Then XOR commit with alu_out=0x8000 → Z=0, N stays 0, V stays 0.
- Same-cycle check: ADD with alu_out=0x0000 while flags Z=0, is_branch=1, ccc=001 → branch_taken=0 that cycle; Z=1 next cycle.
- stall=1 for 3 cycles with changing alu_out → ex_result, ex_valid and flags constant. stall=1 & flush=1 → ex_valid=0, flags unchanged.
- Random sweep of 512 ADD/SUB operands through the adder model → flags match the Z/N/V rules and every ccc matches its condition table.
